inst_encoder: RTL and testbench

- Sequential RISC-V instruction encoder, the inverse of the main decoder.
- Accepts field-level instruction requests over a valid/ready handshake and packs each one into a 32-bit word in R/I/S/J format.
- Writes the words to instruction memory at consecutive addresses and terminates the program with a PAUSE word.
- Used as the program loader that fills imem before the pipeline runs.

---
 rtl/inst_encoder.sv | 184 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Program loader for instruction memory. Takes field-level RISC-V instruction
// requests over a valid/ready handshake and packs each into a 32-bit R/I/S/J
// word. Words go to consecutive imem addresses. The program is terminated
// with a PAUSE word (32'h0000000F). The last imem slot is always kept free so
// that the terminating PAUSE fits.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   req_valid/ready  request handshake (ready independent of valid/finish)
//   req_cls          0 IMMALU, 1 REGALU, 2 LOAD, 3 STORE, 4 JAL, 5 JALR,
//                    6 PAUSE, 7 illegal
//   rd, rs1, rs2     register fields
//   funct3, funct7   function codes
//   imm              immediate (I/S use imm[11:0], J uses imm[20:1])
//   finish           terminate the program with a PAUSE word
//   imem_we          one-cycle write strobe per written word
//   imem_addr        byte address of the written word (held between writes)
//   imem_wdata       encoded word (held between writes)
//   count            words written, including the terminating PAUSE
//   done             program terminated; rises with the PAUSE strobe
//   err              sticky flag, set by an illegal request
// ---------------------------------------------------------------------------
module inst_encoder #(
    parameter int          DEPTH     = 64,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          ADDR_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_cls,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [2:0]                 funct3,
    input  logic [6:0]                 funct7,
    input  logic [20:0]                imm,
    input  logic                       finish,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       done,
    output logic                       err
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(DEPTH - 1);
    localparam logic [31:0]       PAUSE_WORD = 32'h0000000F;

    localparam logic [2:0] CLS_IMMALU  = 3'd0;
    localparam logic [2:0] CLS_REGALU  = 3'd1;
    localparam logic [2:0] CLS_LOAD    = 3'd2;
    localparam logic [2:0] CLS_STORE   = 3'd3;
    localparam logic [2:0] CLS_JAL     = 3'd4;
    localparam logic [2:0] CLS_JALR    = 3'd5;
    localparam logic [2:0] CLS_PAUSE   = 3'd6;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TERM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_err;

    logic                w_ready;
    logic                w_accept;
    logic                w_illegal;
    logic                w_write;
    logic [31:0]         w_word;
    logic [31:0]         w_enc;

    // Slot DEPTH-1 is reserved for PAUSE, so requests stop one word early.
    assign w_ready   = (r_state == S_RUN) && (r_count < LAST_SLOT);
    assign w_accept  = req_valid && w_ready;
    assign w_illegal = w_accept && (req_cls == CLS_ILLEGAL);

    // Field packing for the request currently on the bus.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_enc = PAUSE_WORD;
        case (req_cls)
            CLS_REGALU: w_enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            CLS_IMMALU: begin
                // Shift-immediates carry funct7 above a 5-bit shamt.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    w_enc = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
                else
                    w_enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            end
            CLS_LOAD:   w_enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            CLS_JALR:   w_enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            CLS_STORE:  w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            CLS_JAL:    w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            CLS_PAUSE:  w_enc = PAUSE_WORD;
            default:    w_enc = PAUSE_WORD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic. An accept on the finish edge defers PAUSE by a cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (finish) w_state_nxt = w_accept ? S_TERM : S_DONE;
            S_TERM:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Output logic: what, if anything, is written on this edge.
    always_comb begin
        w_write = 1'b0;
        w_word  = w_enc;
        case (r_state)
            S_RUN: begin
                if (w_accept) begin
                    w_write = !w_illegal;
                end else if (finish) begin
                    w_write = 1'b1;
                    w_word  = PAUSE_WORD;
                end
            end
            S_TERM: begin
                w_write = 1'b1;
                w_word  = PAUSE_WORD;
            end
            default: w_write = 1'b0;
        endcase
    end

    // Write port, pointer and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ptr   <= ADDR_W'(BASE_ADDR);
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_addr  <= r_ptr;
                r_wdata <= w_word;
                r_ptr   <= r_ptr + ADDR_W'(4);
                r_count <= r_count + 1'b1;
            end
            if (w_illegal) r_err <= 1'b1;
        end
    end

    assign req_ready  = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    // DONE is entered on the same edge that registers the PAUSE strobe.
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//
// Directed, table-driven bench for inst_encoder. Instance u_dut uses the
// default DEPTH=64; instance u_dut4 uses DEPTH=4 for the full condition.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before new inputs are applied.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] imm;
    logic        finish;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;
    logic        done;
    logic        err;

    logic        b_valid;
    logic        b_ready;
    logic        b_finish;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;
    logic        b_done;
    logic        b_err;

    int n_checks = 0;
    int n_errors = 0;

    inst_encoder u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cls    (req_cls),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .finish     (finish),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err        (err)
    );

    inst_encoder #(.DEPTH(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_valid),
        .req_ready  (b_ready),
        .req_cls    (req_cls),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .finish     (b_finish),
        .imem_we    (b_we),
        .imem_addr  (b_addr),
        .imem_wdata (b_wdata),
        .count      (b_count),
        .done       (b_done),
        .err        (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [20:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int N_VEC = 13;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_cls = v.cls;
        rd      = v.rd;
        rs1     = v.rs1;
        rs2     = v.rs2;
        funct3  = v.f3;
        funct7  = v.f7;
        imm     = v.imm;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        finish    = 1'b0;
        b_valid   = 1'b0;
        b_finish  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Check the write produced by table entry idx (addr/count from its position).
    task automatic check_write(input int idx);
        check($sformatf("vec%0d we", idx),    {31'd0, imem_we}, 32'd1);
        check($sformatf("vec%0d wdata", idx), imem_wdata, vecs[idx].exp);
        check($sformatf("vec%0d addr", idx),  imem_addr, 32'(4 * idx));
        check($sformatf("vec%0d count", idx), {25'd0, count}, 32'(idx + 1));
    endtask

    initial begin
        // cls, rd, rs1, rs2, f3, f7, imm, expected word; unused fields carry junk
        vecs[0]  = '{3'd0, 5'd1, 5'd0, 5'd9,  3'd0, 7'h55, 21'd5,       32'h00500093}; // addi x1,x0,5
        vecs[1]  = '{3'd1, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 21'h1ABCD,   32'h002081B3}; // add x3,x1,x2
        vecs[2]  = '{3'd1, 5'd3, 5'd1, 5'd2,  3'd0, 7'h20, 21'h00123,   32'h402081B3}; // sub x3,x1,x2
        vecs[3]  = '{3'd2, 5'd5, 5'd1, 5'd31, 3'd2, 7'h7F, 21'd4,       32'h0040A283}; // lw x5,4(x1)
        vecs[4]  = '{3'd3, 5'd31,5'd1, 5'd2,  3'd2, 7'h11, 21'd8,       32'h0020A423}; // sw x2,8(x1)
        vecs[5]  = '{3'd4, 5'd1, 5'd7, 5'd7,  3'd5, 7'h3C, 21'd8,       32'h008000EF}; // jal x1,8
        vecs[6]  = '{3'd0, 5'd4, 5'd1, 5'd0,  3'd5, 7'h20, 21'h00FE3,   32'h4030D213}; // srai x4,x1,3
        vecs[7]  = '{3'd5, 5'd1, 5'd2, 5'd5,  3'd7, 7'h6A, 21'd12,      32'h00C100E7}; // jalr x1,12(x2), f3 ignored
        vecs[8]  = '{3'd3, 5'd0, 5'd2, 5'd3,  3'd2, 7'h00, 21'h1FFFFC,  32'hFE312E23}; // sw x3,-4(x2)
        vecs[9]  = '{3'd4, 5'd0, 5'd3, 5'd4,  3'd1, 7'h01, 21'h1FFFF9,  32'hFF9FF06F}; // jal x0,-8, imm[0] ignored
        vecs[10] = '{3'd6, 5'd9, 5'd9, 5'd9,  3'd7, 7'h7F, 21'h1FFFFF,  32'h0000000F}; // PAUSE word
        vecs[11] = '{3'd0, 5'd6, 5'd7, 5'd3,  3'd7, 7'h7F, 21'h1FFFFF,  32'hFFF3F313}; // andi x6,x7,-1
        vecs[12] = '{3'd0, 5'd2, 5'd2, 5'd0,  3'd1, 7'h00, 21'h0001F,   32'h01F11113}; // slli x2,x2,31

        reset = 1'b1;
        idle();
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst we",    {31'd0, imem_we}, 32'd0);
        check("rst addr",  imem_addr, 32'd0);
        check("rst wdata", imem_wdata, 32'd0);
        check("rst count", {25'd0, count}, 32'd0);
        check("rst done",  {31'd0, done}, 32'd0);
        check("rst err",   {31'd0, err}, 32'd0);
        check("rst ready", {31'd0, req_ready}, 32'd1);

        // Table: back-to-back accepts, one write per cycle.
        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i]);
            req_valid = 1'b1;
            @(negedge clk);
            check_write(i);
        end
        idle();
        @(negedge clk);
        check("idle we",    {31'd0, imem_we}, 32'd0);
        check("idle addr",  imem_addr, 32'(4 * (N_VEC - 1)));
        check("idle wdata", imem_wdata, vecs[N_VEC-1].exp);
        check("idle count", {25'd0, count}, 32'(N_VEC));
        check("pause cls no done", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of back-to-back writes.
        do_reset();
        drive(vecs[1]);
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre-rst we", {31'd0, imem_we}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check("async rst we",    {31'd0, imem_we}, 32'd0);
        check("async rst count", {25'd0, count}, 32'd0);
        check("async rst addr",  imem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(vecs[0]);
        @(negedge clk);
        check("post-rst wdata", imem_wdata, 32'h00500093);
        check("post-rst addr",  imem_addr, 32'd0);
        check("post-rst count", {25'd0, count}, 32'd1);
        idle();

        // Illegal request, then addi.
        do_reset();
        req_cls   = 3'd7;
        req_valid = 1'b1;
        @(negedge clk);
        check("ill we",    {31'd0, imem_we}, 32'd0);
        check("ill err",   {31'd0, err}, 32'd1);
        check("ill count", {25'd0, count}, 32'd0);
        check("ill ready", {31'd0, req_ready}, 32'd1);
        drive(vecs[0]);
        @(negedge clk);
        idle();
        check("ill+addi wdata", imem_wdata, 32'h00500093);
        check("ill+addi addr",  imem_addr, 32'd0);
        check("ill+addi count", {25'd0, count}, 32'd1);
        @(negedge clk);
        check("err sticky", {31'd0, err}, 32'd1);

        // finish together with an accepted addi.
        do_reset();
        drive(vecs[0]);
        req_valid = 1'b1;
        finish    = 1'b1;
        @(negedge clk);
        check("fin word we",    {31'd0, imem_we}, 32'd1);
        check("fin word wdata", imem_wdata, 32'h00500093);
        check("fin word addr",  imem_addr, 32'd0);
        check("fin word done",  {31'd0, done}, 32'd0);
        check("fin term ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("fin pause we",    {31'd0, imem_we}, 32'd1);
        check("fin pause wdata", imem_wdata, 32'h0000000F);
        check("fin pause addr",  imem_addr, 32'd4);
        check("fin pause done",  {31'd0, done}, 32'd1);
        check("fin pause count", {25'd0, count}, 32'd2);
        repeat (3) @(negedge clk);
        check("done ready",  {31'd0, req_ready}, 32'd0);
        check("done we",     {31'd0, imem_we}, 32'd0);
        check("done count",  {25'd0, count}, 32'd2);
        check("done sticky", {31'd0, done}, 32'd1);
        idle();

        // finish with no request: PAUSE written immediately.
        do_reset();
        finish = 1'b1;
        @(negedge clk);
        idle();
        check("fin only wdata", imem_wdata, 32'h0000000F);
        check("fin only addr",  imem_addr, 32'd0);
        check("fin only count", {25'd0, count}, 32'd1);
        check("fin only done",  {31'd0, done}, 32'd1);

        // DEPTH=4: three accepts fill the request slots.
        do_reset();
        drive(vecs[1]);
        b_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("d4 ready full", {31'd0, b_ready}, 32'd0);
        check("d4 count full", {29'd0, b_count}, 32'd3);
        check("d4 last addr",  b_addr, 32'd8);
        @(negedge clk);
        check("d4 no write", {31'd0, b_we}, 32'd0);
        check("d4 hold count", {29'd0, b_count}, 32'd3);
        b_finish = 1'b1;
        @(negedge clk);
        idle();
        check("d4 pause we",    {31'd0, b_we}, 32'd1);
        check("d4 pause wdata", b_wdata, 32'h0000000F);
        check("d4 pause addr",  b_addr, 32'd12);
        check("d4 pause count", {29'd0, b_count}, 32'd4);
        check("d4 done",        {31'd0, b_done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
